// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: fetch FSM encodings, widths and the
// next-PC source selection used by the PC arithmetic.
package instruction_fetch_pkg;

  localparam int DATA_W   = 16;
  localparam int OFFSET_W = 8;

  // Fixed encodings so the decoder and benches can decode the state directly.
  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_ISSUE = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_RESET,
    PC_SEL_FWD,
    PC_SEL_BWD,
    PC_SEL_SEQ
  } pc_sel_e;

  // Soft reset beats forward jump, forward jump beats backward jump.
  function automatic pc_sel_e pc_select(input logic dec_rstn,
                                        input logic dec_jmpf,
                                        input logic dec_jmpb);
    if (!dec_rstn) return PC_SEL_RESET;
    if (dec_jmpf)  return PC_SEL_FWD;
    if (dec_jmpb)  return PC_SEL_BWD;
    return PC_SEL_SEQ;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Program-memory read port: one-cycle request, then read data qualified by valid.
interface instruction_fetch_if #(
  parameter int ADDR_W = 8
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_valid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );

endinterface

// File: rtl/instruction_fetch_pc_next_calc.sv
// Combinational next-PC select: soft reset, forward/backward jump or sequential,
// all modulo 2^ADDR_W with the 8-bit offset zero-extended.
module pc_next_calc
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic [ADDR_W-1:0]   pc,
  input  logic                dec_rstn,
  input  logic                dec_jmpf,
  input  logic                dec_jmpb,
  input  logic [OFFSET_W-1:0] dec_offset,
  output logic [ADDR_W-1:0]   next_pc
);

  logic [ADDR_W-1:0] offset_ext;

  assign offset_ext = ADDR_W'(dec_offset);

  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    next_pc = pc + ADDR_W'(1);
    case (pc_select(dec_rstn, dec_jmpf, dec_jmpb))
      PC_SEL_RESET: next_pc = RESET_PC;
      PC_SEL_FWD:   next_pc = pc + offset_ext;
      PC_SEL_BWD:   next_pc = pc - offset_ext;
      default:      next_pc = pc + ADDR_W'(1);
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: FETCH -> WAIT -> ISSUE loop that reads one instruction word per
// pass from program memory and holds it in cell_data for the decoder.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  instruction_fetch_if.master  mem,
  input  logic                 exec_ready,
  output logic [DATA_W-1:0]    cell_data,
  output logic                 instr_valid,
  output logic [ADDR_W-1:0]    pc,
  input  logic                 dec_rstn,
  input  logic                 dec_jmpf,
  input  logic                 dec_jmpb,
  input  logic [OFFSET_W-1:0]  dec_offset
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] next_pc;
  logic              mem_req_q;

  pc_next_calc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_next_calc (
    .pc         (pc),
    .dec_rstn   (dec_rstn),
    .dec_jmpf   (dec_jmpf),
    .dec_jmpb   (dec_jmpb),
    .dec_offset (dec_offset),
    .next_pc    (next_pc)
  );

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = fetch_pc;

  // NOTE: every register here is a reset-able flop updated with <=; there is no memory array to leave unreset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= FS_FETCH;
      fetch_pc    <= RESET_PC;
      mem_req_q   <= 1'b0;
      cell_data   <= '0;
      instr_valid <= 1'b0;
      pc          <= RESET_PC;
    end else begin
      case (state)
        // Coming out of hard reset the request is not yet up, so the first
        // FETCH spends one cycle raising it; from ISSUE it arrives pre-armed.
        FS_FETCH: begin
          if (mem_req_q) begin
            mem_req_q <= 1'b0;
            state     <= FS_WAIT;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        FS_WAIT: begin
          if (mem.mem_valid) begin
            cell_data   <= mem.mem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            state       <= FS_ISSUE;
          end
        end
        FS_ISSUE: begin
          if (exec_ready) begin
            fetch_pc    <= next_pc;
            instr_valid <= 1'b0;
            mem_req_q   <= 1'b1;
            state       <= FS_FETCH;
          end
        end
        default: begin
          mem_req_q   <= 1'b0;
          instr_valid <= 1'b0;
          state       <= FS_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a latency-programmable memory responder
// plus a table of issue steps with hand-computed PCs, words and next addresses.
module tb_instruction_fetch;

  localparam int         ADDR_W   = 8;
  localparam logic [7:0] RESET_PC = 8'd0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        exec_ready;
  logic        dec_rstn;
  logic        dec_jmpf;
  logic        dec_jmpb;
  logic [7:0]  dec_offset;
  logic [15:0] cell_data;
  logic        instr_valid;
  logic [7:0]  pc;

  instruction_fetch_if #(.ADDR_W(ADDR_W)) mem_bus ();

  instruction_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .mem         (mem_bus),
    .exec_ready  (exec_ready),
    .cell_data   (cell_data),
    .instr_valid (instr_valid),
    .pc          (pc),
    .dec_rstn    (dec_rstn),
    .dec_jmpf    (dec_jmpf),
    .dec_jmpb    (dec_jmpb),
    .dec_offset  (dec_offset)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory word at address a is {a+1, 8'h00}: 0->0100, 3->0400, 255->0000.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    logic [7:0] hi;
    hi = a + 8'd1;
    return {hi, 8'h00};
  endfunction

  int         lat = 0;
  int         resp_cnt = 0;
  logic [7:0] resp_addr = 8'd0;

  // Responder: a request seen at a negedge answers lat cycles into WAIT.
  always @(negedge clk) begin
    mem_bus.mem_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) begin
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_rdata = mem_word(resp_addr);
      end
    end
    if (mem_bus.mem_req === 1'b1) begin
      resp_cnt  = lat + 1;
      resp_addr = mem_bus.mem_addr;
    end
  end

  int          cyc = 0;
  int          b2b = 0;
  int          cd_bad = 0;
  int          req_cyc[$];
  logic        prev_req = 1'b0;
  logic        prev_iv = 1'b0;
  logic        prev_rstn = 1'b0;
  logic [15:0] prev_cd = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && prev_rstn) begin
      if (mem_bus.mem_req && prev_req) b2b <= b2b + 1;
      if (cell_data !== prev_cd && !(instr_valid && !prev_iv)) cd_bad <= cd_bad + 1;
    end
    if (mem_bus.mem_req === 1'b1) req_cyc.push_back(cyc);
    prev_req  <= mem_bus.mem_req;
    prev_iv   <= instr_valid;
    prev_rstn <= rstn;
    prev_cd   <= cell_data;
  end

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
    logic        rst_n;
    logic        jf;
    logic        jb;
    logic [7:0]  off;
    logic [7:0]  nxt;
    logic        stall;
  } step_t;

  step_t steps[13];

  task automatic wait_issue(input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) break;
    end
    check({tag, "_issue_seen"}, instr_valid, 1'b1);
  endtask

  task automatic run_step(input int i);
    step_t s;
    string t;
    s = steps[i];
    t = $sformatf("s%0d", i);
    wait_issue(t);
    check({t, "_pc"}, pc, s.pc);
    check({t, "_data"}, cell_data, s.data);
    dec_rstn   = s.rst_n;
    dec_jmpf   = s.jf;
    dec_jmpb   = s.jb;
    dec_offset = s.off;
    if (s.stall) begin
      exec_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check({t, "_stall_data"}, cell_data, s.data);
        check({t, "_stall_pc"}, pc, s.pc);
        check({t, "_stall_iv"}, instr_valid, 1'b1);
        check({t, "_stall_req"}, mem_bus.mem_req, 1'b0);
      end
    end
    exec_ready = 1'b1;
    @(negedge clk);
    check({t, "_next_addr"}, mem_bus.mem_addr, s.nxt);
    check({t, "_next_req"}, mem_bus.mem_req, 1'b1);
    check({t, "_iv_fall"}, instr_valid, 1'b0);
    exec_ready = 1'b0;
    dec_rstn   = 1'b1;
    dec_jmpf   = 1'b0;
    dec_jmpb   = 1'b0;
    dec_offset = 8'd0;
  endtask

  initial begin
    //            pc      word      rstn  jmpf  jmpb  off    next    stall
    steps[0]  = '{8'd0,   16'h0100, 1'b1, 1'b0, 1'b0, 8'd0,  8'd1,   1'b0};
    steps[1]  = '{8'd1,   16'h0200, 1'b1, 1'b0, 1'b0, 8'd0,  8'd2,   1'b0};
    steps[2]  = '{8'd2,   16'h0300, 1'b1, 1'b0, 1'b0, 8'd0,  8'd3,   1'b0};
    steps[3]  = '{8'd3,   16'h0400, 1'b1, 1'b1, 1'b0, 8'd5,  8'd8,   1'b0};
    steps[4]  = '{8'd8,   16'h0900, 1'b1, 1'b0, 1'b1, 8'd5,  8'd3,   1'b0};
    steps[5]  = '{8'd3,   16'h0400, 1'b1, 1'b0, 1'b1, 8'd5,  8'd254, 1'b0};
    steps[6]  = '{8'd254, 16'hFF00, 1'b1, 1'b0, 1'b0, 8'd0,  8'd255, 1'b0};
    steps[7]  = '{8'd255, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0,  8'd0,   1'b0};
    steps[8]  = '{8'd0,   16'h0100, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0,   1'b0};
    steps[9]  = '{8'd0,   16'h0100, 1'b1, 1'b1, 1'b0, 8'd40, 8'd40,  1'b0};
    steps[10] = '{8'd40,  16'h2900, 1'b0, 1'b1, 1'b0, 8'd7,  8'd0,   1'b0};
    steps[11] = '{8'd0,   16'h0100, 1'b1, 1'b1, 1'b1, 8'd3,  8'd3,   1'b0};
    steps[12] = '{8'd3,   16'h0400, 1'b1, 1'b0, 1'b0, 8'd0,  8'd4,   1'b1};

    rstn       = 1'b0;
    exec_ready = 1'b0;
    dec_rstn   = 1'b1;
    dec_jmpf   = 1'b0;
    dec_jmpb   = 1'b0;
    dec_offset = 8'd0;

    repeat (2) @(negedge clk);
    check("rst_req", mem_bus.mem_req, 1'b0);
    check("rst_addr", mem_bus.mem_addr, 8'd0);
    check("rst_cell", cell_data, 16'h0000);
    check("rst_iv", instr_valid, 1'b0);
    check("rst_pc", pc, 8'd0);

    rstn = 1'b1;
    @(negedge clk);
    check("first_req", mem_bus.mem_req, 1'b1);
    check("first_addr", mem_bus.mem_addr, 8'd0);

    for (int i = 0; i < 12; i++) run_step(i);

    // The fetch after the stall step answers 4 cycles late.
    @(negedge clk);
    lat = 4;
    run_step(12);

    @(negedge clk);
    check("wait_req", mem_bus.mem_req, 1'b0);
    check("wait_iv", instr_valid, 1'b0);
    rstn = 1'b0;
    #1;
    check("async_req", mem_bus.mem_req, 1'b0);
    check("async_addr", mem_bus.mem_addr, 8'd0);
    check("async_pc", pc, 8'd0);
    check("async_cell", cell_data, 16'h0000);
    check("async_iv", instr_valid, 1'b0);
    @(negedge clk);
    lat = 0;
    @(negedge clk);
    check("hold_addr", mem_bus.mem_addr, 8'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("restart_req", mem_bus.mem_req, 1'b1);
    check("restart_addr", mem_bus.mem_addr, 8'd0);

    wait_issue("restart");
    check("restart_pc", pc, 8'd0);
    check("restart_data", cell_data, 16'h0100);
    exec_ready = 1'b1;
    @(negedge clk);
    check("restart_next_addr", mem_bus.mem_addr, 8'd1);
    exec_ready = 1'b0;

    check("req_back_to_back", b2b, 0);
    check("cell_data_stable", cd_bad, 0);
    check("req_count_ok", req_cyc.size() >= 3, 1'b1);
    if (req_cyc.size() >= 3) begin
      check("req_gap_0", req_cyc[1] - req_cyc[0], 3);
      check("req_gap_1", req_cyc[2] - req_cyc[1], 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the processor: holds the program counter, reads 16-bit instruction words from program memory over a request/valid handshake, and presents each word on `cell_data` to the instruction decoder. It consumes the decoder's `jmpf`, `jmpb`, `rstn` (soft reset) and `prog_mem_data` to compute the next program counter. It sits directly upstream of the decoder, between program memory and the decoder.

## Interface
- `ADDR_W`, default 8: program-counter and memory-address width; the jump offset is 8 bits, zero-extended when `ADDR_W` > 8.
- `RESET_PC`, default 0: address loaded on hard reset and on soft reset.
- `clk`  in  1: single clock; all flops are rising-edge.
- `rstn`  in  1: one clock; reset is asynchronous and active-low.
- `mem_req`  out  1: one-cycle read request to program memory.
- `mem_addr`  out  ADDR_W: read address; valid while `mem_req`=1.
- `mem_rdata`  in  16: instruction word; sampled only when `mem_valid`=1 in WAIT.
- `mem_valid`  in  1: read data valid.
- `exec_ready`  in  1: the execute side accepts the presented instruction this cycle.
- `cell_data`  out  16: instruction register; drives the decoder.
- `instr_valid`  out  1: `cell_data` holds a live instruction (ISSUE state).
- `pc`  out  ADDR_W: address of the instruction in `cell_data`.
- `dec_rstn`  in  1: decoder soft-reset output (0 = RST instruction).
- `dec_jmpf`, `dec_jmpb`  in  1 each: decoder jump outputs.
- `dec_offset`  in  8: decoder `prog_mem_data` field.

## Operation
- FSM with 3 states: FETCH → WAIT → ISSUE → FETCH.
- FETCH: assert `mem_req`=1 and `mem_addr`=`fetch_pc` for exactly one cycle, then go to WAIT. Any `mem_valid` seen in FETCH is ignored.
- WAIT: hold until `mem_valid`=1. On that cycle, latch `mem_rdata` into `cell_data`, latch `fetch_pc` into `pc`, and go to ISSUE. There is no timeout; wait latency is unbounded.
- ISSUE: `instr_valid`=1 and `cell_data` is stable. Stay in ISSUE while `exec_ready`=0. On the cycle with `exec_ready`=1, compute `fetch_pc` from the decoder inputs as follows, then go to FETCH:
  - `dec_rstn`=0 → `RESET_PC` (highest priority).
  - else `dec_jmpf`=1 → `pc` + `dec_offset`.
  - else `dec_jmpb`=1 → `pc` − `dec_offset`.
  - else → `pc` + 1.
- If `dec_jmpf` and `dec_jmpb` are both 1, `dec_jmpf` wins; this is not an error.
- All PC arithmetic is modulo 2^ADDR_W (wrap-around in both directions). Offset 0 re-fetches the same address.
- The decoder inputs are combinational functions of `cell_data`, so they are evaluated only in ISSUE and ignored in every other state.

## Timing
- Values after reset:
  - State = FETCH, `fetch_pc` = `RESET_PC`.
  - `mem_req`=0 while reset is asserted; `mem_req`=1 on the first clock after deassertion.
  - `mem_addr` = `RESET_PC`, `cell_data`=16'h0000, `instr_valid`=0, `pc` = `RESET_PC`.
- Minimum throughput is 3 cycles per instruction: FETCH, WAIT with `mem_valid` on its first cycle, ISSUE with `exec_ready`=1.
- `cell_data` changes only on the WAIT→ISSUE edge.
- `instr_valid` rises the cycle after `mem_valid` is sampled and falls the cycle after `exec_ready` is sampled.
- `mem_req` never stays high for 2 consecutive cycles.
- Async reset mid-operation (any state, including a pending memory read) returns to the reset values immediately. A `mem_valid` arriving after reset deasserts is in FETCH and is dropped. Memory must not deliver a stale response once WAIT is re-entered; the memory side guarantees this.
- Soft reset (RST instruction) is not asynchronous: it only redirects the PC and keeps the FSM cycling.

## Structure
- State encodings (`FS_FETCH`, `FS_WAIT`, `FS_ISSUE`) go as `define`s in the shared header alongside the instruction opcodes, so the decoder and the benches can reference them.
- One sub-module, `pc_next_calc`: combinational next-PC select and add/subtract.
  - Inputs: `pc`, `dec_rstn`, `dec_jmpf`, `dec_jmpb`, `dec_offset`.
  - Output: `next_pc`.
  - The FSM and registers stay in `instruction_fetch`.

## Test plan
- Reset, then zero-latency memory returning 16'h0100, 16'h0200, …, with `exec_ready`=1: addresses 0,1,2 are issued, `mem_req` pulses every 3 cycles, and `cell_data` follows memory.
- JMPF with offset 5 at `pc`=3 → next `mem_addr`=8. JMPB with offset 5 at `pc`=3 → next `mem_addr`=254 (wrap, `ADDR_W`=8).
- `pc`=255 with a non-jump instruction → next `mem_addr`=0. JMPF with offset 0 → the same address is re-fetched.
- RST instruction word at `pc`=40 with `exec_ready`=1 → next `mem_addr`=`RESET_PC`. `rstn` stays 1 and the FSM keeps cycling.
- `exec_ready` held 0 for 10 cycles in ISSUE: `cell_data`, `pc` and `instr_valid`=1 stay stable and `mem_req` stays 0. The next fetch follows 1 cycle after `exec_ready`=1.
- `rstn` pulsed low during WAIT with memory responding 4 cycles later: all outputs go to reset values immediately, the late `mem_valid` is dropped, and fetch restarts at `RESET_PC`.
